alu: RTL and testbench
======================

# alu

32-bit registered arithmetic/logic unit used as the execute-stage datapath of the processor. It takes a 4-bit operation code, two 32-bit operands and a 5-bit shift amount, and produces a 32-bit result plus N/Z/V/C status flags. Result and flags are captured in registers on each clock edge for consumption by the writeback and condition-evaluation logic.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- optcode  input  4  operation select (encodings under Operation).
- R2  input  32  operand A.
- R3  input  32  operand B (ignored by shift/rotate ops).
- shift  input  5  shift/rotate amount 0-31 (used only by opcodes 6-8).
- R1  output  32  registered result.
- negative  output  1  registered N flag.
- zero  output  1  registered Z flag.
- overflow  output  1  registered V flag (signed overflow).
- carry  output  1  registered C flag.

## Operation
- 0000 ADD: R1 = A+B mod 2^32; C = carry out of bit 31; V = A,B same sign and result sign differs.
- 0001 SUB: R1 = A-B mod 2^32; C = 1 when no borrow (A >= B unsigned); V = A,B differ in sign and result sign differs from A.
- 0010 MUL: R1 = low 32 bits of unsigned A*B; C = V = 1 when high 32 bits of the 64-bit product nonzero.
- 0011 OR, 0100 AND, 0101 XOR: bitwise; C = V = 0.
- 0110 LSR: R1 = A >> shift, zero fill; C = last bit shifted out (A[shift-1]); V = 0.
- 0111 LSL: R1 = A << shift; C = last bit shifted out (A[32-shift]); V = 0.
- 1000 ROR: R1 = A rotated right by shift; C = A[shift-1] (equals R1[31]); V = 0.
- Shift/rotate with shift = 0: R1 = A, C = 0.
- 1001 CMP: computes A-B with SUB flag rules; flags updated; R1 register holds its previous value.
- 1010-1111 unused: R1 = 0, Z = 1, N = V = C = 0.
- For every op that writes R1: N = result[31], Z = (result == 0). CMP sets N/Z from the difference.

## Timing
- All computation combinational from inputs; R1 and all four flags registered on rising clk.
- Latency: exactly 1 cycle; inputs sampled at edge k appear on outputs after edge k. New operation accepted every cycle; no handshake.
- rst_n low: R1 = 0, negative = 0, zero = 0, overflow = 0, carry = 0 immediately, independent of clk; held while low. Reset asserted mid-operation discards that cycle's result.
- First rising edge after rst_n deassertion captures the current inputs normally.

## Configuration
- ALU_MUL_EN: defined -> opcode 0010 performs MUL as specified. Undefined -> multiplier not synthesized; opcode 0010 behaves as an unused opcode (R1 = 0, Z = 1, N = V = C = 0).

## Test plan
- ADD A=FFFFFFFF, B=FFFFFFFF -> next cycle R1=FFFFFFFE, N=1, Z=0, V=0, C=1; ADD A=7FFFFFFF, B=1 -> R1=80000000, N=1, V=1, C=0.
- SUB A=5, B=1 -> R1=4, C=1, N=0; SUB A=1, B=5 -> R1=FFFFFFFC, N=1, C=0, V=0; MUL A=5, B=2 -> R1=10 (with ALU_MUL_EN), C=V=0.
- OR 5|2 -> 7; AND 7&5 -> 5; XOR 7^2 -> 5; all C=V=0.
- LSR A=8, shift=2 -> 2, C=0; LSR A=3, shift=2 -> 0, Z=1, C=1; LSL A=8, shift=2 -> 32, C=0; LSL A=40000000, shift=2 -> 0, Z=1, C=1.
- ROR A=1, shift=5 -> 08000000, C=0; ROR A=1F, shift=5 -> F8000000, N=1, C=1; CMP 11,11 -> Z=1, C=1, R1 unchanged; CMP 10,11 -> N=1, C=0.
- Drive rst_n low between clock edges mid-sequence -> all outputs 0 immediately; release, apply ADD 5+1 -> R1=6 after first edge.

Source files
------------

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// alu_if : operand/opcode bus into the ALU and registered result/flags out.
// Rev 1.0
// ============================================================================
interface alu_if;
  logic [3:0]  optcode;
  logic [31:0] R2;
  logic [31:0] R3;
  logic [4:0]  shift;
  logic [31:0] R1;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry;

  modport master (
    output optcode, R2, R3, shift,
    input  R1, negative, zero, overflow, carry
  );

  modport slave (
    input  optcode, R2, R3, shift,
    output R1, negative, zero, overflow, carry
  );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// alu : 32-bit registered ALU, result and N/Z/V/C flags valid one cycle later.
// Define ALU_MUL_EN to build the opcode-0010 multiplier.   Rev 1.0
// ============================================================================
module alu (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_MUL = 4'b0010;
  localparam logic [3:0] c_OP_OR  = 4'b0011;
  localparam logic [3:0] c_OP_AND = 4'b0100;
  localparam logic [3:0] c_OP_XOR = 4'b0101;
  localparam logic [3:0] c_OP_LSR = 4'b0110;
  localparam logic [3:0] c_OP_LSL = 4'b0111;
  localparam logic [3:0] c_OP_ROR = 4'b1000;
  localparam logic [3:0] c_OP_CMP = 4'b1001;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_sh;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_sub_v;
  logic [31:0] w_ror;
  logic        w_sh_nz;

  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;
  logic        w_wr;

  logic [31:0] r1_d, r1_q;
  logic        n_d, n_q;
  logic        z_d, z_q;
  logic        v_d, v_q;
  logic        c_d, c_q;

  assign w_a     = bus.R2;
  assign w_b     = bus.R3;
  assign w_sh    = bus.shift;
  assign w_sh_nz = (w_sh != 5'd0);
  assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
  // Bit 32 of the 33-bit difference is the borrow; carry is its inverse.
  assign w_diff  = {1'b0, w_a} - {1'b0, w_b};
  assign w_sub_v = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
  // A left shift by 32 (shift = 0) yields zero, so the rotate degenerates to A.
  assign w_ror   = (w_a >> w_sh) | (w_a << (6'd32 - {1'b0, w_sh}));

`ifdef ALU_MUL_EN
  logic [63:0] w_prod;
  assign w_prod = {32'd0, w_a} * {32'd0, w_b};
`endif

  always_comb begin
    w_res = 32'd0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_wr  = 1'b1;
    case (bus.optcode)
      c_OP_ADD: begin
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
      end
      c_OP_SUB: begin
        w_res = w_diff[31:0];
        w_c   = ~w_diff[32];
        w_v   = w_sub_v;
      end
`ifdef ALU_MUL_EN
      c_OP_MUL: begin
        w_res = w_prod[31:0];
        w_c   = |w_prod[63:32];
        w_v   = |w_prod[63:32];
      end
`endif
      c_OP_OR:  w_res = w_a | w_b;
      c_OP_AND: w_res = w_a & w_b;
      c_OP_XOR: w_res = w_a ^ w_b;
      c_OP_LSR: begin
        w_res = w_a >> w_sh;
        w_c   = w_sh_nz && w_a[w_sh - 5'd1];
      end
      c_OP_LSL: begin
        // 0 - shift wraps to 32 - shift for shift in 1..31.
        w_res = w_a << w_sh;
        w_c   = w_sh_nz && w_a[5'd0 - w_sh];
      end
      c_OP_ROR: begin
        w_res = w_ror;
        w_c   = w_sh_nz && w_a[w_sh - 5'd1];
      end
      c_OP_CMP: begin
        w_res = w_diff[31:0];
        w_c   = ~w_diff[32];
        w_v   = w_sub_v;
        w_wr  = 1'b0;
      end
      default: begin
        w_res = 32'd0;
      end
    endcase
  end

  assign r1_d = w_wr ? w_res : r1_q;
  assign n_d  = w_res[31];
  assign z_d  = (w_res == 32'd0);
  assign v_d  = w_v;
  assign c_d  = w_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= 32'd0;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
      v_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      r1_q <= r1_d;
      n_q  <= n_d;
      z_q  <= z_d;
      v_q  <= v_d;
      c_q  <= c_d;
    end
  end

  assign bus.R1       = r1_q;
  assign bus.negative = n_q;
  assign bus.zero     = z_q;
  assign bus.overflow = v_q;
  assign bus.carry    = c_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// tb_alu : directed + random ALU stimulus, queued expectations, checking monitor.
// Rev 1.0
// ============================================================================
module tb_alu;

  typedef struct {
    logic [31:0] r1;
    logic        n, z, v, c;
    string       name;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  alu_if bus ();
  exp_t  sb_q[$];
  logic [31:0] m_r1 = 32'd0;
  int    n_checks = 0;
  int    n_pass = 0;

  alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got R1=%h NZVC=%b, expected R1=%h NZVC=%b",
                  name, act[35:4], act[3:0], exp[35:4], exp[3:0]);
  endtask

  // Reference model: plain wide arithmetic and bit-by-bit rotation.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    logic [31:0] res;
    logic [63:0] u;
    longint sr;
    int s;
    bit c, v, wr;
    res = 32'd0; c = 0; v = 0; wr = 1; s = int'(sh);
    case (op)
      4'd0: begin
        u = 64'(a) + 64'(b); res = u[31:0]; c = u[32];
        sr = longint'($signed(a)) + longint'($signed(b));
        v = (sr != longint'($signed(res)));
      end
      4'd1, 4'd9: begin
        res = a - b; c = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        v = (sr != longint'($signed(res)));
        wr = (op == 4'd1);
      end
`ifdef ALU_MUL_EN
      4'd2: begin
        u = 64'(a) * 64'(b); res = u[31:0];
        c = ((u >> 32) != 64'd0); v = c;
      end
`endif
      4'd3: res = a | b;
      4'd4: res = a & b;
      4'd5: res = a ^ b;
      4'd6: begin res = a >> s; c = (s != 0) && (((a >> (s - 1)) & 32'd1) != 0); end
      4'd7: begin res = a << s; c = (s != 0) && (((a >> (32 - s)) & 32'd1) != 0); end
      4'd8: begin
        res = a;
        for (int i = 0; i < s; i++) res = {res[0], res[31:1]};
        c = (s != 0) && res[31];
      end
      default: res = 32'd0;
    endcase
    e.r1 = wr ? res : m_r1;
    e.n = res[31]; e.z = (res == 32'd0); e.v = v; e.c = c; e.name = name;
    m_r1 = e.r1;
    @(negedge clk);
    bus.optcode = op; bus.R2 = a; bus.R3 = b; bus.shift = sh;
    sb_q.push_back(e);
  endtask

  // Monitor: every active edge with reset released presents one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, {bus.R1, bus.negative, bus.zero, bus.overflow, bus.carry},
            {e.r1, e.n, e.z, e.v, e.c});
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drain();
    int budget;
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk); #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    bus.optcode = 4'd0; bus.R2 = 32'd0; bus.R3 = 32'd0; bus.shift = 5'd0;
    #1;
    chk("reset_state", {bus.R1, bus.negative, bus.zero, bus.overflow, bus.carry}, 36'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add_ff_ff",   4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    issue("add_ovf",     4'd0, 32'h7FFF_FFFF, 32'd1,         5'd0);
    issue("sub_5_1",     4'd1, 32'd5,         32'd1,         5'd0);
    issue("sub_1_5",     4'd1, 32'd1,         32'd5,         5'd0);
    issue("mul_5_2",     4'd2, 32'd5,         32'd2,         5'd0);
    issue("mul_big",     4'd2, 32'h0001_0000, 32'h0001_0000, 5'd0);
    issue("or_5_2",      4'd3, 32'd5,         32'd2,         5'd0);
    issue("and_7_5",     4'd4, 32'd7,         32'd5,         5'd0);
    issue("xor_7_2",     4'd5, 32'd7,         32'd2,         5'd0);
    issue("lsr_8_2",     4'd6, 32'd8,         32'd0,         5'd2);
    issue("lsr_3_2",     4'd6, 32'd3,         32'd0,         5'd2);
    issue("lsl_8_2",     4'd7, 32'd8,         32'd0,         5'd2);
    issue("lsl_4000_2",  4'd7, 32'h4000_0000, 32'd0,         5'd2);
    issue("ror_1_5",     4'd8, 32'd1,         32'd0,         5'd5);
    issue("ror_1f_5",    4'd8, 32'h1F,        32'd0,         5'd5);
    issue("lsr_sh0",     4'd6, 32'h8000_0001, 32'd0,         5'd0);
    issue("ror_sh0",     4'd8, 32'h8000_0001, 32'd0,         5'd0);
    issue("lsl_sh31",    4'd7, 32'h0000_0003, 32'd0,         5'd31);
    issue("cmp_11_11",   4'd9, 32'd11,        32'd11,        5'd0);
    issue("cmp_10_11",   4'd9, 32'd10,        32'd11,        5'd0);
    issue("unused_a",    4'd10, 32'hFFFF_FFFF, 32'd1,        5'd3);
    issue("unused_f",    4'd15, 32'h1234_5678, 32'd9,        5'd1);

    for (int i = 0; i < 300; i++)
      issue($sformatf("rand_%0d", i), 4'($urandom_range(0, 15)), pick(), pick(),
            5'($urandom_range(0, 31)));

    issue("pre_reset_add", 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    drain();

    // Asynchronous reset between clock edges.
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.R1, bus.negative, bus.zero, bus.overflow, bus.carry}, 36'd0);
    @(posedge clk); #1;
    chk("reset_held", {bus.R1, bus.negative, bus.zero, bus.overflow, bus.carry}, 36'd0);
    m_r1 = 32'd0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    issue("post_reset_add", 4'd0, 32'd5, 32'd1, 5'd0);
    issue("post_reset_cmp", 4'd9, 32'd3, 32'd7, 5'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
